// File: rtl/id_stage_fwd.sv
// ---------------------------------------------------------------------------
// id_stage_fwd
//   Decode-stage register read with prioritised forwarding, branch-condition
//   evaluation for NPC, and the ID/EX pipeline register.
//
// Ports
//   clk, reset (async, active-low)    clock and reset
//   hold, bubble                      ID/EX register control (hold wins)
//   valid_ID, addrRs_ID, addrRt_ID    ID slot and its source registers
//   RD1_GRF, RD2_GRF                  register file read data
//   fwdAddr/fwdData/fwdValid          NFWD forwarding channels, ch0 youngest
//   cmpMode                           branch compare selector
//   regWriteAddr_ID, Tnew_ID          destination and result timing at ID
//   payload_ID                        opaque pass-through bits
//   cmp_NPC, jmpReg_NPC               combinational branch outputs
//   *_EX                              registered EX-stage copies
//   stallCnt                          bubble-only cycle counter (only when
//                                     ID_STALL_CNT_EN is defined)
//
// Optional feature macro: ID_STALL_CNT_EN
// ---------------------------------------------------------------------------
module id_stage_fwd #(
  parameter int DW   = 32,
  parameter int NFWD = 2,   // must be >= 1
  parameter int TW   = 2,
  parameter int PW   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic              valid_ID,
  input  logic [4:0]        addrRs_ID,
  input  logic [4:0]        addrRt_ID,
  input  logic [DW-1:0]     RD1_GRF,
  input  logic [DW-1:0]     RD2_GRF,
  input  logic [NFWD*5-1:0] fwdAddr,
  input  logic [NFWD*DW-1:0] fwdData,
  input  logic [NFWD-1:0]   fwdValid,
  input  logic [2:0]        cmpMode,
  input  logic [4:0]        regWriteAddr_ID,
  input  logic [TW-1:0]     Tnew_ID,
  input  logic [PW-1:0]     payload_ID,
  output logic              cmp_NPC,
  output logic [DW-1:0]     jmpReg_NPC,
  output logic              valid_EX,
  output logic [4:0]        addrRs_EX,
  output logic [4:0]        addrRt_EX,
  output logic [4:0]        regWriteAddr_EX,
  output logic [TW-1:0]     Tnew_EX,
  output logic [DW-1:0]     dataRs_EX,
  output logic [DW-1:0]     dataRt_EX,
  output logic [PW-1:0]     payload_EX
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0]       stallCnt
`endif
);
  // Purpose: operand forwarding, branch compare and ID/EX register.
  // Latency: 0 cycles to cmp_NPC/jmpReg_NPC, 1 cycle ID to EX.
  // Backpressure: hold freezes EX (operands still refresh), bubble inserts a NOP.

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_EQ   = 3'd1;
  localparam logic [2:0] CMP_NE   = 3'd2;
  localparam logic [2:0] CMP_GEZ  = 3'd3;
  localparam logic [2:0] CMP_GTZ  = 3'd4;
  localparam logic [2:0] CMP_LEZ  = 3'd5;
  localparam logic [2:0] CMP_LTZ  = 3'd6;

  // Returns the data of the lowest-index valid channel whose destination
  // equals addr, or dflt when nothing matches. Register 0 never forwards.
  // Scanning from the highest index down lets lower indices overwrite, so
  // the youngest producer wins.
  function automatic logic [DW-1:0] fwd_select(
    input logic [4:0]         addr,
    input logic [DW-1:0]      dflt,
    input logic [NFWD*5-1:0]  f_addr,
    input logic [NFWD*DW-1:0] f_data,
    input logic [NFWD-1:0]    f_vld
  );
    logic [DW-1:0] r;
    r = dflt;
    if (addr != 5'd0) begin
      for (int i = NFWD - 1; i >= 0; i--) begin
        if (f_vld[i] && (f_addr[5*i +: 5] == addr)) begin
          r = f_data[DW*i +: DW];
        end
      end
    end
    return r;
  endfunction

  // ---- ID-side operand selection -----------------------------------------
  logic [DW-1:0] rs_id;
  logic [DW-1:0] rt_id;

  always_comb begin
    rs_id = fwd_select(addrRs_ID, RD1_GRF, fwdAddr, fwdData, fwdValid);
    rt_id = fwd_select(addrRt_ID, RD2_GRF, fwdAddr, fwdData, fwdValid);
  end

  assign jmpReg_NPC = rs_id;

  // ---- Branch compare ----------------------------------------------------
  logic rs_neg;
  logic rs_zero;
  logic cmp_raw;

  assign rs_neg  = rs_id[DW-1];
  assign rs_zero = (rs_id == '0);

  always_comb begin
    cmp_raw = 1'b0;
    unique case (cmpMode)
      CMP_NONE: cmp_raw = 1'b0;
      CMP_EQ:   cmp_raw = (rs_id == rt_id);
      CMP_NE:   cmp_raw = (rs_id != rt_id);
      CMP_GEZ:  cmp_raw = !rs_neg;
      CMP_GTZ:  cmp_raw = !rs_neg && !rs_zero;
      CMP_LEZ:  cmp_raw = rs_neg || rs_zero;
      CMP_LTZ:  cmp_raw = rs_neg;
      default:  cmp_raw = 1'b0;   // mode 7 reserved
    endcase
  end

  // An empty ID slot must never redirect fetch.
  assign cmp_NPC = cmp_raw && valid_ID;

  // ---- EX-side refresh while held ----------------------------------------
  // A held instruction may have been waiting on a producer that completes
  // during the hold; re-sampling the channels keeps its operands current.
  logic [DW-1:0] rs_ex_refresh;
  logic [DW-1:0] rt_ex_refresh;

  always_comb begin
    rs_ex_refresh = fwd_select(addrRs_EX, dataRs_EX, fwdAddr, fwdData, fwdValid);
    rt_ex_refresh = fwd_select(addrRt_EX, dataRt_EX, fwdAddr, fwdData, fwdValid);
  end

  // Tnew counts down one stage per pipeline step and saturates at zero.
  logic [TW-1:0] tnew_dec;
  assign tnew_dec = (Tnew_ID == '0) ? '0 : (Tnew_ID - 1'b1);

  // ---- ID/EX register ----------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_EX        <= 1'b0;
      addrRs_EX       <= '0;
      addrRt_EX       <= '0;
      regWriteAddr_EX <= '0;
      Tnew_EX         <= '0;
      dataRs_EX       <= '0;
      dataRt_EX       <= '0;
      payload_EX      <= '0;
    end else if (hold) begin
      // hold outranks bubble so a stalled EX instruction is never lost
      if (valid_EX) begin
        dataRs_EX <= rs_ex_refresh;
        dataRt_EX <= rt_ex_refresh;
      end
    end else if (bubble) begin
      valid_EX        <= 1'b0;
      addrRs_EX       <= '0;
      addrRt_EX       <= '0;
      regWriteAddr_EX <= '0;
      Tnew_EX         <= '0;
      dataRs_EX       <= '0;
      dataRt_EX       <= '0;
      payload_EX      <= '0;
    end else begin
      valid_EX        <= valid_ID;
      addrRs_EX       <= addrRs_ID;
      addrRt_EX       <= addrRt_ID;
      regWriteAddr_EX <= regWriteAddr_ID;
      Tnew_EX         <= tnew_dec;
      dataRs_EX       <= rs_id;
      dataRt_EX       <= rt_id;
      payload_EX      <= payload_ID;
    end
  end

`ifdef ID_STALL_CNT_EN
  // Counts only cycles where a NOP actually entered EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= 16'h0000;
    end else if (bubble && !hold && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
module tb_id_stage_fwd;
  localparam int DW = 32;
  localparam int NFWD = 2;
  localparam int TW = 2;
  localparam int PW = 64;

  logic              clk;
  logic              reset;
  logic              hold, bubble, valid_ID;
  logic [4:0]        addrRs_ID, addrRt_ID, regWriteAddr_ID;
  logic [DW-1:0]     RD1_GRF, RD2_GRF;
  logic [NFWD*5-1:0] fwdAddr;
  logic [NFWD*DW-1:0] fwdData;
  logic [NFWD-1:0]   fwdValid;
  logic [2:0]        cmpMode;
  logic [TW-1:0]     Tnew_ID;
  logic [PW-1:0]     payload_ID;
  logic              cmp_NPC;
  logic [DW-1:0]     jmpReg_NPC;
  logic              valid_EX;
  logic [4:0]        addrRs_EX, addrRt_EX, regWriteAddr_EX;
  logic [TW-1:0]     Tnew_EX;
  logic [DW-1:0]     dataRs_EX, dataRt_EX;
  logic [PW-1:0]     payload_EX;
`ifdef ID_STALL_CNT_EN
  logic [15:0]       stallCnt;
`endif

  id_stage_fwd #(.DW(DW), .NFWD(NFWD), .TW(TW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .valid_ID(valid_ID),
    .addrRs_ID(addrRs_ID), .addrRt_ID(addrRt_ID), .RD1_GRF(RD1_GRF), .RD2_GRF(RD2_GRF),
    .fwdAddr(fwdAddr), .fwdData(fwdData), .fwdValid(fwdValid), .cmpMode(cmpMode),
    .regWriteAddr_ID(regWriteAddr_ID), .Tnew_ID(Tnew_ID), .payload_ID(payload_ID),
    .cmp_NPC(cmp_NPC), .jmpReg_NPC(jmpReg_NPC), .valid_EX(valid_EX),
    .addrRs_EX(addrRs_EX), .addrRt_EX(addrRt_EX), .regWriteAddr_EX(regWriteAddr_EX),
    .Tnew_EX(Tnew_EX), .dataRs_EX(dataRs_EX), .dataRt_EX(dataRt_EX),
    .payload_EX(payload_EX)
`ifdef ID_STALL_CNT_EN
    , .stallCnt(stallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference EX slot
  typedef struct packed {
    logic         v;
    logic [4:0]   rs, rt, wa;
    logic [TW-1:0] tn;
    logic [DW-1:0] drs, drt;
    logic [PW-1:0] pl;
  } ex_t;

  ex_t m, mn;
  int unsigned scnt, scnt_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: first valid channel (youngest) naming addr wins.
  function automatic logic [DW-1:0] ref_pick(input logic [4:0] addr, input logic [DW-1:0] dflt);
    if (addr == 0) return dflt;
    for (int i = 0; i < NFWD; i++)
      if (fwdValid[i] && fwdAddr[5*i +: 5] == addr) return fwdData[DW*i +: DW];
    return dflt;
  endfunction

  function automatic logic ref_cmp();
    int signed rs, rt;
    rs = $signed(ref_pick(addrRs_ID, RD1_GRF));
    rt = $signed(ref_pick(addrRt_ID, RD2_GRF));
    if (!valid_ID) return 1'b0;
    case (cmpMode)
      3'd1: return rs == rt;
      3'd2: return rs != rt;
      3'd3: return rs >= 0;
      3'd4: return rs > 0;
      3'd5: return rs <= 0;
      3'd6: return rs < 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    hold = 0; bubble = 0; valid_ID = 0; addrRs_ID = 0; addrRt_ID = 0;
    RD1_GRF = 0; RD2_GRF = 0; fwdAddr = 0; fwdData = 0; fwdValid = 0;
    cmpMode = 0; regWriteAddr_ID = 0; Tnew_ID = 0; payload_ID = 0;
  endtask

  task automatic set_ch(input int ch, input logic [4:0] a, input logic [DW-1:0] d, input logic v);
    fwdAddr[5*ch +: 5] = a;
    fwdData[DW*ch +: DW] = d;
    fwdValid[ch] = v;
  endtask

  // Advance one clock edge, updating the model from the inputs seen at the edge.
  task automatic step();
    int tn;
    mn = m;
    if (hold) begin
      if (m.v) begin
        mn.drs = ref_pick(m.rs, m.drs);
        mn.drt = ref_pick(m.rt, m.drt);
      end
    end else if (bubble) begin
      mn = '0;
    end else begin
      tn = int'(Tnew_ID) - 1;
      if (tn < 0) tn = 0;
      mn.v = valid_ID; mn.rs = addrRs_ID; mn.rt = addrRt_ID; mn.wa = regWriteAddr_ID;
      mn.tn = TW'(tn);
      mn.drs = ref_pick(addrRs_ID, RD1_GRF);
      mn.drt = ref_pick(addrRt_ID, RD2_GRF);
      mn.pl = payload_ID;
    end
    scnt_n = scnt;
    if (bubble && !hold && scnt < 65535) scnt_n = scnt + 1;
    @(posedge clk);
    m = mn;
    scnt = scnt_n;
    @(negedge clk);
  endtask

  task automatic chk_regs(input string pfx);
    chk({pfx, ".valid_EX"}, 64'(valid_EX), 64'(m.v));
    chk({pfx, ".addrRs_EX"}, 64'(addrRs_EX), 64'(m.rs));
    chk({pfx, ".addrRt_EX"}, 64'(addrRt_EX), 64'(m.rt));
    chk({pfx, ".regWriteAddr_EX"}, 64'(regWriteAddr_EX), 64'(m.wa));
    chk({pfx, ".Tnew_EX"}, 64'(Tnew_EX), 64'(m.tn));
    chk({pfx, ".dataRs_EX"}, 64'(dataRs_EX), 64'(m.drs));
    chk({pfx, ".dataRt_EX"}, 64'(dataRt_EX), 64'(m.drt));
    chk({pfx, ".payload_EX"}, 64'(payload_EX), 64'(m.pl));
`ifdef ID_STALL_CNT_EN
    chk({pfx, ".stallCnt"}, 64'(stallCnt), 64'(scnt));
`endif
  endtask

  task automatic chk_comb(input string pfx);
    chk({pfx, ".jmpReg_NPC"}, 64'(jmpReg_NPC), 64'(ref_pick(addrRs_ID, RD1_GRF)));
    chk({pfx, ".cmp_NPC"}, 64'(cmp_NPC), 64'(ref_cmp()));
  endtask

  function automatic logic [DW-1:0] rnd_data();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'(int'($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    reset = 0;
    m = '0;
    scnt = 0;
    #1;
    chk_regs("reset");
    chk("reset.valid_EX_zero", 64'(valid_EX), 64'd0);

    @(negedge clk);
    @(negedge clk);
    reset = 1;

    // Forwarding priority
    addrRs_ID = 5; RD1_GRF = 32'h11;
    set_ch(0, 5, 32'hAA, 1); set_ch(1, 5, 32'hBB, 1);
    #1 chk("fwd.ch0_wins", 64'(jmpReg_NPC), 64'hAA);
    fwdValid[0] = 0;
    #1 chk("fwd.ch1_only", 64'(jmpReg_NPC), 64'hBB);
    addrRs_ID = 0; set_ch(0, 0, 32'hAA, 1); set_ch(1, 0, 32'hBB, 1);
    #1 chk("fwd.r0_grf", 64'(jmpReg_NPC), 64'h11);
    idle();

    // Compare modes
    valid_ID = 1; addrRs_ID = 1; RD1_GRF = 32'h8000_0000;
    cmpMode = 6; #1 chk("cmp.ltz_neg", 64'(cmp_NPC), 64'd1);
    cmpMode = 5; #1 chk("cmp.lez_neg", 64'(cmp_NPC), 64'd1);
    cmpMode = 3; #1 chk("cmp.gez_neg", 64'(cmp_NPC), 64'd0);
    cmpMode = 4; #1 chk("cmp.gtz_neg", 64'(cmp_NPC), 64'd0);
    RD1_GRF = 0;
    cmpMode = 4; #1 chk("cmp.gtz_zero", 64'(cmp_NPC), 64'd0);
    cmpMode = 3; #1 chk("cmp.gez_zero", 64'(cmp_NPC), 64'd1);
    addrRt_ID = 2; RD1_GRF = 7; RD2_GRF = 7;
    cmpMode = 1; #1 chk("cmp.eq", 64'(cmp_NPC), 64'd1);
    cmpMode = 2; #1 chk("cmp.ne_eq", 64'(cmp_NPC), 64'd0);
    cmpMode = 7; #1 chk("cmp.reserved", 64'(cmp_NPC), 64'd0);
    cmpMode = 1; valid_ID = 0; #1 chk("cmp.invalid", 64'(cmp_NPC), 64'd0);
    idle();
    @(negedge clk);

    // Load and Tnew
    valid_ID = 1; Tnew_ID = 2; payload_ID = 64'h1234; regWriteAddr_ID = 3;
    step();
    chk("load.valid_EX", 64'(valid_EX), 64'd1);
    chk("load.Tnew_EX", 64'(Tnew_EX), 64'd1);
    chk("load.payload_EX", 64'(payload_EX), 64'h1234);
    chk_regs("load");
    Tnew_ID = 0;
    step();
    chk("load.Tnew_sat", 64'(Tnew_EX), 64'd0);

    // Hold with refresh
    idle();
    valid_ID = 1; addrRt_ID = 9; RD2_GRF = 32'h5; payload_ID = 64'hCAFE;
    step();
    chk("hold.load_rt", 64'(dataRt_EX), 64'h5);
    idle(); hold = 1;
    step();
    chk("hold.c1_rt", 64'(dataRt_EX), 64'h5);
    set_ch(1, 9, 32'h77, 1);
    step();
    chk("hold.c2_rt", 64'(dataRt_EX), 64'h77);
    chk("hold.c2_payload", 64'(payload_EX), 64'hCAFE);
    set_ch(1, 0, 0, 0);
    step();
    chk("hold.c3_rt", 64'(dataRt_EX), 64'h77);
    chk_regs("hold");
    bubble = 1;
    step();
    chk("holdbub.valid_EX", 64'(valid_EX), 64'd1);
    chk("holdbub.dataRt_EX", 64'(dataRt_EX), 64'h77);
    chk_regs("holdbub");

    // Bubble
    hold = 0; bubble = 1;
    step();
    chk("bubble.payload_EX", 64'(payload_EX), 64'd0);
    chk_regs("bubble");

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      hold = ($urandom_range(0, 9) < 3);
      bubble = ($urandom_range(0, 9) < 2);
      valid_ID = $urandom_range(0, 1);
      addrRs_ID = 5'($urandom_range(0, 3));
      addrRt_ID = 5'($urandom_range(0, 3));
      regWriteAddr_ID = 5'($urandom_range(0, 31));
      RD1_GRF = rnd_data(); RD2_GRF = rnd_data();
      for (int c = 0; c < NFWD; c++)
        set_ch(c, 5'($urandom_range(0, 3)), rnd_data(), 1'($urandom_range(0, 1)));
      cmpMode = 3'($urandom_range(0, 7));
      Tnew_ID = TW'($urandom_range(0, 3));
      payload_ID = {$urandom, $urandom};
      #1 chk_comb("rnd");
      step();
      chk_regs("rnd");
    end

    // Reset mid-hold clears outputs before the next edge
    idle();
    valid_ID = 1; addrRs_ID = 4; RD1_GRF = 32'h99; payload_ID = 64'h55;
    step();
    hold = 1;
    #2 reset = 0;
    #1;
    m = '0; scnt = 0;
    chk("arst.valid_EX", 64'(valid_EX), 64'd0);
    chk("arst.dataRs_EX", 64'(dataRs_EX), 64'd0);
    chk("arst.payload_EX", 64'(payload_EX), 64'd0);
    chk_regs("arst");
    @(negedge clk);
    reset = 1;
    step();
    chk_regs("arst_rel");

`ifdef ID_STALL_CNT_EN
    idle();
    reset = 0; #1; m = '0; scnt = 0;
    @(negedge clk); reset = 1;
    bubble = 1;
    for (int k = 0; k < 3; k++) step();
    hold = 1;
    for (int k = 0; k < 2; k++) step();
    chk("stall.count3", 64'(stallCnt), 64'd3);
    hold = 0;
    for (int k = 0; k < 65540; k++) step();
    chk("stall.sat", 64'(stallCnt), 64'hFFFF);
    chk_regs("stall");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised decode-stage register-read and ID/EX pipeline block. It merges GRF read data with NFWD prioritised forwarding channels and evaluates the branch condition for NPC. It registers an opaque instruction payload into the EX stage with bubble/hold control. While the register is held, it refreshes its operand registers from live forwarding channels.

## Interface
Parameters:
- DW, 32, datapath width
- NFWD, 2, forwarding channels; channel 0 has highest priority (youngest producer)
- TW, 2, Tnew width
- PW, 64, opaque payload width (instr symbol, PC, imm, shamt, link data)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- hold  in  1  freeze ID/EX register (downstream busy)
- bubble  in  1  load a NOP slot into EX (hazard stall or flush)
- valid_ID  in  1  ID slot holds a real instruction
- addrRs_ID, addrRt_ID  in  5 each  source register numbers
- RD1_GRF, RD2_GRF  in  DW each  GRF read data (GRF forwards internally from WB)
- fwdAddr  in  NFWD*5  destination register per channel, channel i at [5i+4:5i]
- fwdData  in  NFWD*DW  data per channel
- fwdValid  in  NFWD  data on channel is final
- cmpMode  in  3  0 none, 1 EQ, 2 NE, 3 GEZ, 4 GTZ, 5 LEZ, 6 LTZ, 7 reserved
- regWriteAddr_ID  in  5  destination register
- Tnew_ID  in  TW  cycles until result ready, counted at ID
- payload_ID  in  PW  opaque pass-through
- cmp_NPC  out  1  branch-taken condition (combinational)
- jmpReg_NPC  out  DW  forwarded rs value (combinational)
- valid_EX, addrRs_EX, addrRt_EX, regWriteAddr_EX, Tnew_EX, dataRs_EX, dataRt_EX, payload_EX  out  registered copies

## Operation
- Operand select, per source: the lowest-index channel i with fwdValid[i], fwdAddr_i == addr and addr != 0 supplies the operand. If no channel matches, the GRF value is used. Register 0 always reads as the GRF value.
- Compare on the selected operands, evaluated on rs:
  - EQ: rs == rt. NE: rs != rt.
  - GEZ: rs[DW-1] == 0. GTZ: GEZ and rs != 0.
  - LEZ: rs[DW-1] == 1 or rs == 0. LTZ: rs[DW-1] == 1.
  - Modes 0 and 7 give 0.
  - cmp_NPC is forced to 0 when valid_ID is 0.
- Tnew_EX loads max(Tnew_ID - 1, 0).
- Register update priority per clock edge:
  - reset low: all outputs 0.
  - Else hold: all fields keep their values, except the refresh rule below.
  - Else bubble: all registered outputs 0, valid_EX = 0.
  - Else load: all fields from ID; valid_EX = valid_ID.
- Hold refresh: while hold is high and valid_EX is 1, dataRs_EX reloads from the highest-priority channel that matches addrRs_EX with fwdValid set and a nonzero address. dataRt_EX follows the same rule using addrRt_EX. A non-matching operand keeps its value.
- If hold and bubble are both high, hold wins; the EX instruction is preserved.

## Timing
- Combinational paths: forwarding inputs and GRF data to cmp_NPC and jmpReg_NPC, within the same cycle.
- ID-to-EX latency: 1 cycle.
- Asserting reset clears all outputs immediately, without waiting for a clock edge. This holds mid-hold or mid-refresh.
- Deasserting reset takes effect at the first rising edge after release.
- Tnew saturates at 0; there is no wrap.
- NFWD = 1 is legal. NFWD = 0 is not supported.

## Configuration
- ID_STALL_CNT_EN defined:
  - Adds output stallCnt, out, 16 bits.
  - Increments on each edge where bubble = 1 and hold = 0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- ID_STALL_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Forwarding priority: addrRs_ID = 5, RD1 = 0x11; ch0 (addr 5, data 0xAA, valid) and ch1 (addr 5, data 0xBB, valid) -> jmpReg_NPC = 0xAA. Set fwdValid[0] = 0 -> 0xBB. Set addrRs_ID = 0 with channels at addr 0 -> 0x11.
- Compare modes: rs = 0x8000_0000 -> LTZ = 1, LEZ = 1, GEZ = 0, GTZ = 0. rs = 0 -> GTZ = 0, GEZ = 1. EQ with rs = rt = 7 -> 1. Mode 7 -> 0. valid_ID = 0 with EQ and equal operands -> 0.
- Load and Tnew: Tnew_ID = 2, payload 0x1234, valid_ID = 1 -> after 1 edge valid_EX = 1, Tnew_EX = 1, payload_EX = 0x1234. Tnew_ID = 0 -> Tnew_EX = 0.
- Hold with refresh: load addrRt = 9 with data 0x5; hold for 3 cycles; in cycle 2, ch1 carries (addr 9, data 0x77, valid) -> dataRt_EX = 0x77 from the next edge on, other fields unchanged. Assert bubble together with hold -> no change.
- Bubble and reset: bubble for 1 cycle -> every registered output is 0. Pull reset low mid-cycle during hold -> outputs read 0 before the next clock edge.
- With ID_STALL_CNT_EN: 3 bubble-only cycles plus 2 bubble+hold cycles -> stallCnt = 3. Preload near saturation -> stallCnt holds at 0xFFFF.
